// File: rtl/chunk_sub_pkg.sv
// Shared definitions for chunk_sub_ctrl: FSM state encoding and the legal
// CHUNKS range checked at elaboration.
package chunk_sub_pkg;

    localparam int unsigned CHUNKS_MIN = 2;
    localparam int unsigned CHUNKS_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : chunk_sub_pkg

// File: rtl/sub_slice.sv
// sub_slice: combinational WIDTH-bit ripple-borrow subtractor slice.
// Ports:
//   i_op1, i_op2 : WIDTH-bit minuend / subtrahend slice
//   i_borrow     : borrow-in from the less significant slice
//   o_res        : WIDTH-bit difference slice
//   o_borrow     : borrow-out to the more significant slice
module sub_slice #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_borrow,
    output logic [WIDTH-1:0] o_res,
    output logic             o_borrow
);

    // Bitwise ripple: borrow propagates LSB to MSB through one full subtractor per bit.
    always_comb begin
        logic w_b;
        w_b   = i_borrow;
        o_res = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            o_res[i] = i_op1[i] ^ i_op2[i] ^ w_b;
            w_b      = (~i_op1[i] & i_op2[i]) | (~(i_op1[i] ^ i_op2[i]) & w_b);
        end
        o_borrow = w_b;
    end

endmodule : sub_slice

// File: rtl/chunk_sub_ctrl.sv
// chunk_sub_ctrl: multi-cycle N-bit subtractor (N = WIDTH*CHUNKS) that processes
// one WIDTH-bit slice per cycle, least significant first, with a valid/ready
// handshake on both request and result sides.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_valid / o_ready     : request handshake (accepted only in IDLE)
//   i_op1, i_op2, i_borrow: operands and borrow-in, latched on accept
//   o_valid / i_ready     : result handshake (o_valid only in DONE)
//   o_res, o_borrow       : difference modulo 2^N and final borrow-out
//   o_ovf                 : signed overflow, present only with CHUNK_SUB_SIGNED_OVF_EN
// Optional feature macro: CHUNK_SUB_SIGNED_OVF_EN
module chunk_sub_ctrl
    import chunk_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [WIDTH*CHUNKS-1:0] i_op1,
    input  logic [WIDTH*CHUNKS-1:0] i_op2,
    input  logic                    i_borrow,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIDTH*CHUNKS-1:0] o_res,
`ifdef CHUNK_SUB_SIGNED_OVF_EN
    output logic                    o_ovf,
`endif
    output logic                    o_borrow
);

    localparam int unsigned N     = WIDTH * CHUNKS;
    localparam int unsigned CNT_W = $clog2(CHUNKS);

    if (CHUNKS < CHUNKS_MIN || CHUNKS > CHUNKS_MAX) begin : g_bad_chunks
        $error("chunk_sub_ctrl: CHUNKS out of legal range");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ready;
    logic               r_valid;
    logic [N-1:0]       r_op1;
    logic [N-1:0]       r_op2;
    logic [N-1:0]       r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_sl_op1;
    logic [WIDTH-1:0]   w_sl_op2;
    logic [WIDTH-1:0]   w_sl_res;
    logic               w_sl_borrow;

    assign w_last = (r_cnt == CNT_W'(CHUNKS - 1));

    // Counter-indexed slice select of the latched operands.
    always_comb begin
        w_sl_op1 = '0;
        w_sl_op2 = '0;
        for (int k = 0; k < int'(CHUNKS); k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_sl_op1 = r_op1[k*WIDTH +: WIDTH];
                w_sl_op2 = r_op2[k*WIDTH +: WIDTH];
            end
        end
    end

    sub_slice #(.WIDTH(WIDTH)) u_sub_slice (
        .i_op1    (w_sl_op1),
        .i_op2    (w_sl_op2),
        .i_borrow (r_borrow),
        .o_res    (w_sl_res),
        .o_borrow (w_sl_borrow)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = i_valid;
                if (i_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE: if (i_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Datapath: latch on accept, then one slice per RUN cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_op1    <= i_op1;
            r_op2    <= i_op2;
            r_borrow <= i_borrow;
            r_cnt    <= '0;
        end else if (r_state == ST_RUN) begin
            r_borrow <= w_sl_borrow;
            for (int k = 0; k < int'(CHUNKS); k++) begin
                if (r_cnt == CNT_W'(k)) r_res[k*WIDTH +: WIDTH] <= w_sl_res;
            end
            // Counter parks on the last slice so it never wraps within a request.
            if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef CHUNK_SUB_SIGNED_OVF_EN
    logic r_ovf;

    // Signed overflow: operand signs differ and result sign differs from minuend.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_RUN && w_last) begin
            r_ovf <= (r_op1[N-1] ^ r_op2[N-1]) & (w_sl_res[WIDTH-1] ^ r_op1[N-1]);
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_res    = r_res;
    assign o_borrow = r_borrow;

endmodule : chunk_sub_ctrl

// File: tb/tb_chunk_sub_ctrl.sv
// Directed bench for chunk_sub_ctrl: a 4x4 instance for handshake, latency,
// stall and reset scenarios, and a 2x2 instance swept over every input value.
module tb_chunk_sub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: WIDTH=4, CHUNKS=4
    logic        a_rst, a_valid, a_ready, a_bin, a_ovalid, a_iready, a_bout;
    logic [15:0] a_op1, a_op2, a_res;
`ifdef CHUNK_SUB_SIGNED_OVF_EN
    logic        a_ovf;
`endif

    chunk_sub_ctrl #(.WIDTH(4), .CHUNKS(4)) u_dut_a (
        .i_clk    (clk),
        .i_rst    (a_rst),
        .i_valid  (a_valid),
        .o_ready  (a_ready),
        .i_op1    (a_op1),
        .i_op2    (a_op2),
        .i_borrow (a_bin),
        .o_valid  (a_ovalid),
        .i_ready  (a_iready),
        .o_res    (a_res),
`ifdef CHUNK_SUB_SIGNED_OVF_EN
        .o_ovf    (a_ovf),
`endif
        .o_borrow (a_bout)
    );

    // Instance B: WIDTH=2, CHUNKS=2
    logic       b_rst, b_valid, b_ready, b_bin, b_ovalid, b_iready, b_bout;
    logic [3:0] b_op1, b_op2, b_res;
`ifdef CHUNK_SUB_SIGNED_OVF_EN
    logic       b_ovf;
`endif

    chunk_sub_ctrl #(.WIDTH(2), .CHUNKS(2)) u_dut_b (
        .i_clk    (clk),
        .i_rst    (b_rst),
        .i_valid  (b_valid),
        .o_ready  (b_ready),
        .i_op1    (b_op1),
        .i_op2    (b_op2),
        .i_borrow (b_bin),
        .o_valid  (b_ovalid),
        .i_ready  (b_iready),
        .o_res    (b_res),
`ifdef CHUNK_SUB_SIGNED_OVF_EN
        .o_ovf    (b_ovf),
`endif
        .o_borrow (b_bout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Issue one request on A (must be in IDLE); returns cycles from accept to o_valid.
    task automatic run_a(input logic [15:0] op1, input logic [15:0] op2, input logic bi,
                         output int lat);
        a_op1 = op1; a_op2 = op2; a_bin = bi; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        lat = 0;
        while (!a_ovalid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_b(input logic [3:0] op1, input logic [3:0] op2, input logic bi,
                         output int lat);
        b_op1 = op1; b_op2 = op2; b_bin = bi; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        lat = 0;
        while (!b_ovalid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume_a();
        a_iready = 1'b1;
        tick();
        a_iready = 1'b0;
        check("a_consume_valid", 32'(a_ovalid), 32'd0);
        check("a_consume_ready", 32'(a_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic seen_valid;
        logic [4:0] exp5;

        a_rst = 1'b1; a_valid = 1'b0; a_bin = 1'b0; a_iready = 1'b0; a_op1 = '0; a_op2 = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_bin = 1'b0; b_iready = 1'b0; b_op1 = '0; b_op2 = '0;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        check("rst_ready",  32'(a_ready),  32'd1);
        check("rst_valid",  32'(a_ovalid), 32'd0);
        check("rst_res",    32'(a_res),    32'd0);
        check("rst_borrow", 32'(a_bout),   32'd0);

        // 0x1234 - 0x0235 - 0
        run_a(16'h1234, 16'h0235, 1'b0, lat);
        check("t1_latency", 32'(lat),    32'd4);
        check("t1_res",     32'(a_res),  32'h0FFF);
        check("t1_borrow",  32'(a_bout), 32'd0);
        check("t1_ready",   32'(a_ready), 32'd0);
`ifdef CHUNK_SUB_SIGNED_OVF_EN
        check("t1_ovf", 32'(a_ovf), 32'd0);
`endif
        consume_a();

        // 0x0000 - 0x0001 - 0
        run_a(16'h0000, 16'h0001, 1'b0, lat);
        check("t2_latency", 32'(lat),    32'd4);
        check("t2_res",     32'(a_res),  32'hFFFF);
        check("t2_borrow",  32'(a_bout), 32'd1);
`ifdef CHUNK_SUB_SIGNED_OVF_EN
        check("t2_ovf", 32'(a_ovf), 32'd0);
`endif
        // Request presented during the consuming DONE edge is not taken there
        a_op1 = 16'h8000; a_op2 = 16'h0000; a_bin = 1'b1; a_valid = 1'b1; a_iready = 1'b1;
        tick();
        a_iready = 1'b0;
        check("t2_done_exit_ready", 32'(a_ready),  32'd1);
        check("t2_done_exit_valid", 32'(a_ovalid), 32'd0);

        // 0x8000 - 0x0000 - 1: accepted on the following edge
        run_a(16'h8000, 16'h0000, 1'b1, lat);
        check("t3_latency", 32'(lat),    32'd4);
        check("t3_res",     32'(a_res),  32'h7FFF);
        check("t3_borrow",  32'(a_bout), 32'd0);
`ifdef CHUNK_SUB_SIGNED_OVF_EN
        check("t3_ovf", 32'(a_ovf), 32'd1);
`endif
        consume_a();

        // Stall in DONE for 3 cycles with a stray request pulse
        run_a(16'h5678, 16'h1234, 1'b0, lat);
        check("t4_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                a_op1 = 16'hFFFF; a_op2 = 16'h0000; a_bin = 1'b0; a_valid = 1'b1;
            end
            tick();
            a_valid = 1'b0;
            check("t4_stall_valid",  32'(a_ovalid), 32'd1);
            check("t4_stall_ready",  32'(a_ready),  32'd0);
            check("t4_stall_res",    32'(a_res),    32'h4444);
            check("t4_stall_borrow", 32'(a_bout),   32'd0);
        end
        consume_a();
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_ovalid) seen_valid = 1'b1;
        end
        check("t4_pulse_ignored_valid", 32'(seen_valid), 32'd0);
        check("t4_pulse_ignored_res",   32'(a_res),      32'h4444);
        check("t4_idle_ready",          32'(a_ready),    32'd1);

        // Reset while slice 2 is pending in RUN
        a_op1 = 16'hFFFF; a_op2 = 16'h0001; a_bin = 1'b0; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check("t5_rst_ready",  32'(a_ready),  32'd1);
        check("t5_rst_valid",  32'(a_ovalid), 32'd0);
        check("t5_rst_res",    32'(a_res),    32'd0);
        check("t5_rst_borrow", 32'(a_bout),   32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_ovalid) seen_valid = 1'b1;
        end
        check("t5_aborted_no_valid", 32'(seen_valid), 32'd0);

        // 0xABCD - 0x1234 - 1 after the abort
        run_a(16'hABCD, 16'h1234, 1'b1, lat);
        check("t6_latency", 32'(lat),    32'd4);
        check("t6_res",     32'(a_res),  32'h9998);
        check("t6_borrow",  32'(a_bout), 32'd0);
`ifdef CHUNK_SUB_SIGNED_OVF_EN
        check("t6_ovf", 32'(a_ovf), 32'd0);
`endif
        consume_a();

        // Exhaustive sweep on the 2x2 instance against op1 - op2 - borrow (5 bits)
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    run_b(4'(x), 4'(y), 1'(c), lat);
                    exp5 = 5'(x) - 5'(y) - 5'(c);
                    check("ex_latency", 32'(lat), 32'd2);
                    check($sformatf("ex_%0d_%0d_%0d", x, y, c), 32'({b_bout, b_res}), 32'(exp5));
                    b_iready = 1'b1;
                    tick();
                    b_iready = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_chunk_sub_ctrl
